// File: rtl/seven_seg_pkg.sv
// Shared constants and state encoding for the multiplexed seven-segment display driver.
package seven_seg_pkg;
    localparam int         DIGITS    = 8;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {ST_BLANK, ST_ON} state_e;
endpackage

// File: rtl/seven_seg_scan_decode.sv
// Hex nibble to active-low cathode pattern {dp,g,f,e,d,c,b,a}; dp is always off here.
module SevenSegDecode (
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);
    always_comb begin
        seg_o = 8'hFF;
        case (nibble_i)
            4'h0: seg_o = 8'hC0;
            4'h1: seg_o = 8'hF9;
            4'h2: seg_o = 8'hA4;
            4'h3: seg_o = 8'hB0;
            4'h4: seg_o = 8'h99;
            4'h5: seg_o = 8'h92;
            4'h6: seg_o = 8'h82;
            4'h7: seg_o = 8'hF8;
            4'h8: seg_o = 8'h80;
            4'h9: seg_o = 8'h90;
            4'hA: seg_o = 8'h88;
            4'hB: seg_o = 8'h83;
            4'hC: seg_o = 8'hA7;
            4'hD: seg_o = 8'hA1;
            4'hE: seg_o = 8'h86;
            4'hF: seg_o = 8'h8E;
            default: seg_o = 8'hFF;
        endcase
    end
endmodule

// File: rtl/seven_seg_scan.sv
// 8-digit common-anode scan driver with blanking gaps and frame-boundary double buffering.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int NUM_DIGITS   = 8
) (
    input  logic              Clk_I,
    input  logic              Rst_I,
    input  logic [31:0]       Value_I,
    input  logic [DIGITS-1:0] DpEn_I,
    input  logic [DIGITS-1:0] DigitEn_I,
    input  logic              Load_I,
    output logic [7:0]        Led_AN_O,
    output logic [7:0]        Led_CA_O,
    output logic              FrameDone_O
);
    localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);
    localparam state_e           START_ST   = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
    localparam state_e           AFTER_ON   = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          idx_q;
    logic [7:0]          an_q, ca_q;
    logic                fd_q;

    logic [31:0]         pend_val_q, act_val_q;
    logic [DIGITS-1:0]   pend_dp_q, act_dp_q;
    logic [DIGITS-1:0]   pend_en_q, act_en_q;
    logic                pend_flag_q;

    logic                on_last, commit;
    logic [2:0]          idx_d;
    logic [3:0]          nibble;
    logic [7:0]          dec_seg, an_onehot, an_d, ca_d;

    assign nibble = act_val_q[{idx_q, 2'b00} +: 4];

    SevenSegDecode u_decode (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    always_comb begin
        on_last   = (state_q == ST_ON) && (cnt_q == ON_LAST);
        commit    = on_last && (idx_q == IDX_LAST);
        idx_d     = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        an_onehot = 8'd1 << idx_q;
        an_d      = SEG_BLANK;
        ca_d      = SEG_BLANK;
        // A disabled digit stays fully dark: neither anode nor cathodes are driven.
        if (state_q == ST_ON && act_en_q[idx_q]) begin
            an_d = ~an_onehot;
            ca_d = {dec_seg[7] & ~act_dp_q[idx_q], dec_seg[6:0]};
        end
    end

    always_ff @(posedge Clk_I) begin
        if (Rst_I) begin
            state_q     <= START_ST;
            cnt_q       <= '0;
            idx_q       <= '0;
            an_q        <= SEG_BLANK;
            ca_q        <= SEG_BLANK;
            fd_q        <= 1'b0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_en_q   <= '0;
            pend_flag_q <= 1'b0;
            act_val_q   <= '0;
            act_dp_q    <= '0;
            act_en_q    <= '0;
        end else begin
            an_q <= an_d;
            ca_q <= ca_d;
            fd_q <= commit;

            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= ST_ON;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_q <= AFTER_ON;
                        cnt_q   <= '0;
                        idx_q   <= idx_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= START_ST;
                    cnt_q   <= '0;
                end
            endcase

            // A load coinciding with the commit bypasses the pending buffer entirely.
            if (commit) begin
                if (Load_I) begin
                    act_val_q <= Value_I;
                    act_dp_q  <= DpEn_I;
                    act_en_q  <= DigitEn_I;
                end else if (pend_flag_q) begin
                    act_val_q <= pend_val_q;
                    act_dp_q  <= pend_dp_q;
                    act_en_q  <= pend_en_q;
                end
                pend_flag_q <= 1'b0;
            end else if (Load_I) begin
                pend_val_q  <= Value_I;
                pend_dp_q   <= DpEn_I;
                pend_en_q   <= DigitEn_I;
                pend_flag_q <= 1'b1;
            end
        end
    end

    assign Led_AN_O    = an_q;
    assign Led_CA_O    = ca_q;
    assign FrameDone_O = fd_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with ON_CYCLES=4, BLANK_CYCLES=2: timeline model plus literal pins.
module tb_seven_seg_scan;
    localparam int ON = 4;
    localparam int BL = 2;
    localparam int P  = ON + BL;
    localparam int F  = 8 * P;

    logic        clk = 1'b0;
    logic        rst, load;
    logic [31:0] val;
    logic [7:0]  dp, en;
    logic [7:0]  an, ca;
    logic        fd;

    always #5 clk = ~clk;

    seven_seg_scan #(.ON_CYCLES(ON), .BLANK_CYCLES(BL), .NUM_DIGITS(8)) dut (
        .Clk_I       (clk),
        .Rst_I       (rst),
        .Value_I     (val),
        .DpEn_I      (dp),
        .DigitEn_I   (en),
        .Load_I      (load),
        .Led_AN_O    (an),
        .Led_CA_O    (ca),
        .FrameDone_O (fd)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] seg_tbl [16];

    // Model: cycle t since reset release fixes digit (t/P)%8, slot position t%P and commit t%F==F-1.
    int          t;
    logic [31:0] m_val, p_val;
    logic [7:0]  m_dp, m_en, p_dp, p_en;
    bit          p_flag;
    logic [16:0] exp_q[$];

    logic [7:0]  obs_an, obs_ca;
    logic        obs_fd;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic step();
        logic [16:0] e;
        logic [3:0]  nib;
        logic [7:0]  one;
        int          d, pos;
        bit          commit;
        if (rst) begin
            e      = {8'hFF, 8'hFF, 1'b0};
            t      = 0;
            m_val  = '0; m_dp = '0; m_en = '0;
            p_val  = '0; p_dp = '0; p_en = '0;
            p_flag = 0;
        end else begin
            pos    = t % P;
            d      = (t / P) % 8;
            commit = (t % F) == F - 1;
            nib    = m_val[4*d +: 4];
            one    = 8'd1 << d;
            e      = {8'hFF, 8'hFF, commit};
            if (pos >= BL && m_en[d])
                e = {~one, ~m_dp[d], seg_tbl[nib][6:0], commit};
            if (commit) begin
                if (load) begin
                    m_val = val; m_dp = dp; m_en = en;
                end else if (p_flag) begin
                    m_val = p_val; m_dp = p_dp; m_en = p_en;
                end
                p_flag = 0;
            end else if (load) begin
                p_val = val; p_dp = dp; p_en = en;
                p_flag = 1;
            end
            t++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e      = exp_q.pop_front();
        obs_an = an;
        obs_ca = ca;
        obs_fd = fd;
        check8("an", an, e[16:9]);
        check8("ca", ca, e[8:1]);
        check8("frame_done", {7'd0, fd}, {7'd0, e[0]});
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
        val  = v;
        dp   = d;
        en   = e;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_fd();
        for (int i = 0; i < 60; i++) begin
            step();
            if (obs_fd) begin
                checks++;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL fd_timeout: got no pulse in 60 cycles required a pulse");
    endtask

    int fd_cnt, lit_cnt, one_cnt;

    initial begin
        seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};
        rst = 1'b1; load = 1'b0; val = '0; dp = '0; en = '0;
        t = 0; p_flag = 0;
        for (int i = 0; i < 3; i++) step();
        check8("reset_an", obs_an, 8'hFF);
        check8("reset_ca", obs_ca, 8'hFF);
        rst = 1'b0;

        // Idle: dark throughout, frame pulse every 48 clocks.
        fd_cnt = 0; lit_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (obs_fd) fd_cnt++;
            if (obs_an != 8'hFF || obs_ca != 8'hFF) lit_cnt++;
        end
        check8("idle_fd_count", 8'(fd_cnt), 8'd4);
        check8("idle_lit_count", 8'(lit_cnt), 8'd0);

        // Basic load committed at the next frame boundary.
        do_load(32'h0123ABCD, 8'h01, 8'hFF);
        wait_fd();
        for (int k = 1; k <= 48; k++) begin
            step();
            if (k <= 2) check8("d0_blank_an", obs_an, 8'hFF);
            if (k >= 3 && k <= 6) begin
                check8("d0_an", obs_an, 8'hFE);
                check8("d0_ca", obs_ca, 8'h21);
            end
            if (k >= 45) begin
                check8("d7_an", obs_an, 8'h7F);
                check8("d7_ca", obs_ca, 8'hC0);
            end
            if (k == 48) check8("frame_period_fd", {7'd0, obs_fd}, 8'd1);
        end

        // Two loads in one frame: last one wins.
        do_load(32'h11111111, 8'h00, 8'hFF);
        for (int i = 0; i < 5; i++) step();
        do_load(32'h22222222, 8'h00, 8'hFF);
        wait_fd();
        one_cnt = 0;
        for (int k = 1; k <= 48; k++) begin
            step();
            if (obs_ca == 8'hF9) one_cnt++;
            if (k == 3) check8("two_ca", obs_ca, 8'hA4);
        end
        check8("one_never_shown", 8'(one_cnt), 8'd0);

        // Load on the commit cycle itself.
        for (int i = 0; i < 47; i++) step();
        val = 32'hFFFFFFFF; dp = 8'h00; en = 8'hFF; load = 1'b1;
        step();
        load = 1'b0;
        check8("commit_cycle_fd", {7'd0, obs_fd}, 8'd1);
        for (int k = 1; k <= 48; k++) begin
            step();
            if (k == 3 || k == 27) check8("direct_commit_ca", obs_ca, 8'h8E);
        end
        for (int k = 1; k <= 48; k++) begin
            step();
            if (k == 3) check8("no_stale_ca", obs_ca, 8'h8E);
        end

        // Alternate digits disabled.
        do_load(32'h0123ABCD, 8'h00, 8'hAA);
        wait_fd();
        for (int k = 1; k <= 48; k++) begin
            step();
            if (k == 3) check8("dis_d0_an", obs_an, 8'hFF);
            if (k == 9) begin
                check8("en_d1_an", obs_an, 8'hFD);
                check8("en_d1_ca", obs_ca, 8'hA7);
            end
        end

        // Reset while digit 3 is lit with data pending.
        do_load(32'h44444444, 8'h00, 8'hFF);
        for (int i = 0; i < 20; i++) step();
        check8("d3_lit_an", obs_an, 8'hF7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check8("midscan_rst_an", obs_an, 8'hFF);
        check8("midscan_rst_ca", obs_ca, 8'hFF);
        lit_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (obs_an != 8'hFF) lit_cnt++;
        end
        check8("pending_discarded", 8'(lit_cnt), 8'd0);
        do_load(32'h55555555, 8'h00, 8'hFF);
        wait_fd();
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 3) check8("after_rst_ca", obs_ca, 8'h92);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
